// File: rtl/reg_bank_if.sv
// Operand/write-back bus between the datapath and the architectural register bank.
// The master drives write-back, claim, step and control requests; the slave returns state.
interface reg_bank_if #(
    parameter int WIDTH = 16
);
    logic               wr_en;
    logic [2:0]         wr_targ;
    logic [WIDTH-1:0]   wr_data;
    logic               step_en;
    logic               claim_en;
    logic [2:0]         claim_targ;
    logic [2:0]         rd_a_targ;
    logic [2:0]         rd_b_targ;
    logic               halt_req;
    logic               resume;
    logic [WIDTH-1:0]   pc;
    logic [6*WIDTH-1:0] reg_file;
    logic [7:0]         busy;
    logic               hazard;
    logic               halted;

    modport master (
        output wr_en, wr_targ, wr_data, step_en, claim_en, claim_targ,
               rd_a_targ, rd_b_targ, halt_req, resume,
        input  pc, reg_file, busy, hazard, halted
    );

    modport slave (
        input  wr_en, wr_targ, wr_data, step_en, claim_en, claim_targ,
               rd_a_targ, rd_b_targ, halt_req, resume,
        output pc, reg_file, busy, hazard, halted
    );
endinterface

// File: rtl/reg_bank.sv
// PC + R2..R7 store with busy scoreboard and RUN/HALT FSM; writes visible one cycle after the edge.
// No backpressure: one write-back per cycle is always accepted; issue stalls on hazard.
module reg_bank #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_bank_if.slave   bus
);
    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_regs [2:7];
    logic [7:0]       r_busy;
    logic [7:0]       w_busy_nxt;
    logic             w_run;
    logic             w_pc_wr;

    assign w_run   = (r_state == ST_RUN);
    assign w_pc_wr = bus.wr_en && (bus.wr_targ == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // In RUN a halt request dominates; in HALT a resume dominates.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (bus.halt_req) w_state_nxt = ST_HALT;
            ST_HALT: if (bus.resume)   w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= PC_RESET;
        end else if (w_pc_wr) begin
            r_pc <= bus.wr_data;
        end else if (bus.step_en && w_run) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 2; n < 8; n++) begin
                r_regs[n] <= '0;
            end
        end else if (bus.wr_en) begin
            for (int n = 2; n < 8; n++) begin
                if (bus.wr_targ == 3'(n)) begin
                    r_regs[n] <= bus.wr_data;
                end
            end
        end
    end

    // A new claim outranks a retiring write to the same target.
    always_comb begin
        w_busy_nxt = r_busy;
        w_busy_nxt[0] = 1'b0;
        for (int n = 1; n < 8; n++) begin
            if (bus.claim_en && w_run && (bus.claim_targ == 3'(n))) begin
                w_busy_nxt[n] = 1'b1;
            end else if (bus.wr_en && (bus.wr_targ == 3'(n))) begin
                w_busy_nxt[n] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.reg_file = {r_regs[2], r_regs[3], r_regs[4], r_regs[5], r_regs[6], r_regs[7]};
    assign bus.busy     = r_busy;
    assign bus.hazard   = r_busy[bus.rd_a_targ] | r_busy[bus.rd_b_targ];
    assign bus.halted   = (r_state == ST_HALT);
endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: write-back, PC control, scoreboard, HALT FSM, async reset.
module tb_reg_bank;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    reg_bank_if #(.WIDTH(16)) bus ();

    reg_bank #(.WIDTH(16), .PC_RESET(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en      = 1'b0;
        bus.wr_targ    = 3'd0;
        bus.wr_data    = 16'h0000;
        bus.step_en    = 1'b0;
        bus.claim_en   = 1'b0;
        bus.claim_targ = 3'd0;
        bus.halt_req   = 1'b0;
        bus.resume     = 1'b0;
    endtask

    // Apply the currently driven inputs across one rising edge, then return them to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        bus.rd_a_targ = 3'd0;
        bus.rd_b_targ = 3'd0;
        rst_n = 1'b0;
        #12;
        chk("rst_pc",       96'(bus.pc), 96'h0);
        chk("rst_reg_file", bus.reg_file, 96'h0);
        chk("rst_busy",     96'(bus.busy), 96'h0);
        chk("rst_hazard",   96'(bus.hazard), 96'h0);
        chk("rst_halted",   96'(bus.halted), 96'h0);
        rst_n = 1'b1;
        #1;

        for (int n = 2; n < 8; n++) begin
            bus.wr_en   = 1'b1;
            bus.wr_targ = 3'(n);
            bus.wr_data = 16'(16'h1111 * n);
            step();
        end
        bus.wr_en = 1'b1; bus.wr_targ = 3'd0; bus.wr_data = 16'hFFFF;
        step();
        chk("wr_all_regs", bus.reg_file, 96'h2222_3333_4444_5555_6666_7777);
        chk("wr_t0_pc",    96'(bus.pc), 96'h0);
        chk("wr_t0_busy",  96'(bus.busy), 96'h0);

        bus.wr_en = 1'b1; bus.wr_targ = 3'd1; bus.wr_data = 16'hFFFF;
        step();
        chk("pc_write", 96'(bus.pc), 96'hFFFF);
        bus.step_en = 1'b1;
        step();
        chk("pc_wrap", 96'(bus.pc), 96'h0000);
        bus.step_en = 1'b1; bus.wr_en = 1'b1; bus.wr_targ = 3'd1; bus.wr_data = 16'h0040;
        step();
        chk("pc_jump_over_step", 96'(bus.pc), 96'h0040);
        bus.step_en = 1'b1;
        step();
        chk("pc_step", 96'(bus.pc), 96'h0041);

        bus.rd_a_targ = 3'd3;
        bus.claim_en = 1'b1; bus.claim_targ = 3'd3;
        #1;
        chk("hazard_before_claim_edge", 96'(bus.hazard), 96'h0);
        step();
        chk("claim_busy",   96'(bus.busy), 96'h08);
        chk("claim_hazard", 96'(bus.hazard), 96'h1);
        bus.rd_a_targ = 3'd2; bus.rd_b_targ = 3'd0;
        #1;
        chk("no_hazard_other", 96'(bus.hazard), 96'h0);
        bus.rd_b_targ = 3'd3;
        #1;
        chk("hazard_rd_b", 96'(bus.hazard), 96'h1);
        bus.wr_en = 1'b1; bus.wr_targ = 3'd3; bus.wr_data = 16'h0303;
        #1;
        chk("no_bypass", 96'(bus.hazard), 96'h1);
        step();
        chk("write_clears", 96'(bus.busy), 96'h00);
        chk("write_r3", bus.reg_file, 96'h2222_0303_4444_5555_6666_7777);
        bus.claim_en = 1'b1; bus.claim_targ = 3'd3;
        step();
        bus.claim_en = 1'b1; bus.claim_targ = 3'd3;
        bus.wr_en = 1'b1; bus.wr_targ = 3'd3; bus.wr_data = 16'h3333;
        step();
        chk("claim_and_write", 96'(bus.busy), 96'h08);
        bus.claim_en = 1'b1; bus.claim_targ = 3'd0;
        bus.rd_a_targ = 3'd0; bus.rd_b_targ = 3'd0;
        step();
        chk("claim_t0", 96'(bus.busy), 96'h08);
        chk("hazard_t0", 96'(bus.hazard), 96'h0);
        bus.wr_en = 1'b1; bus.wr_targ = 3'd4; bus.wr_data = 16'h4444;
        step();
        chk("write_non_busy", 96'(bus.busy), 96'h08);

        bus.halt_req = 1'b1; bus.step_en = 1'b1;
        step();
        chk("halt_pc_step", 96'(bus.pc), 96'h0042);
        chk("halt_rise",    96'(bus.halted), 96'h1);
        bus.step_en = 1'b1; bus.claim_en = 1'b1; bus.claim_targ = 3'd5;
        bus.wr_en = 1'b1; bus.wr_targ = 3'd5; bus.wr_data = 16'hBEEF;
        step();
        chk("halt_no_step",  96'(bus.pc), 96'h0042);
        chk("halt_no_claim", 96'(bus.busy), 96'h08);
        chk("halt_write",    bus.reg_file, 96'h2222_3333_4444_BEEF_6666_7777);
        chk("halt_stays",    96'(bus.halted), 96'h1);
        bus.wr_en = 1'b1; bus.wr_targ = 3'd1; bus.wr_data = 16'h1234;
        step();
        chk("halt_pc_write", 96'(bus.pc), 96'h1234);
        bus.resume = 1'b1; bus.halt_req = 1'b1;
        step();
        chk("resume_wins", 96'(bus.halted), 96'h0);

        bus.wr_en = 1'b1; bus.wr_targ = 3'd7; bus.wr_data = 16'hABCD;
        bus.claim_en = 1'b1; bus.claim_targ = 3'd6;
        step();
        bus.halt_req = 1'b1; bus.resume = 1'b1;
        step();
        chk("pre_rst_halted", 96'(bus.halted), 96'h1);
        chk("pre_rst_busy",   96'(bus.busy), 96'h48);
        chk("pre_rst_pc",     96'(bus.pc), 96'h1234);
        chk("pre_rst_regs",   bus.reg_file, 96'h2222_3333_4444_BEEF_6666_ABCD);
        bus.step_en = 1'b1; bus.claim_en = 1'b1; bus.claim_targ = 3'd2;
        bus.rd_a_targ = 3'd6;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",       96'(bus.pc), 96'h0);
        chk("arst_reg_file", bus.reg_file, 96'h0);
        chk("arst_busy",     96'(bus.busy), 96'h0);
        chk("arst_hazard",   96'(bus.hazard), 96'h0);
        chk("arst_halted",   96'(bus.halted), 96'h0);
        rst_n = 1'b1;
        idle();
        bus.step_en = 1'b1;
        step();
        chk("post_rst_run_step", 96'(bus.pc), 96'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
